// File: rtl/mmult_seq_if.sv
// mmult_seq_if -- control/status bundle for the MMULT sequencer.
//
// Requests from the GPU/bus side (go, mwidth_in, colmaj_in, mtxa_wr,
// mem_ready, abort) flow into the sequencer. Address-counter controls
// (cntld, cnten, maddw, mwidth), accumulator strobes
// (macc_first, macc_en, macc_last) and status (busy, done, err) flow out.
//   master : the requester side (drives the inputs of the sequencer)
//   slave  : the sequencer itself
interface mmult_seq_if;
  logic       go;
  logic [3:0] mwidth_in;
  logic       colmaj_in;
  logic       mtxa_wr;
  logic       mem_ready;
  logic       abort;

  logic       cntld;
  logic       cnten;
  logic       maddw;
  logic [3:0] mwidth;
  logic       macc_first;
  logic       macc_en;
  logic       macc_last;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output go, mwidth_in, colmaj_in, mtxa_wr, mem_ready, abort,
    input  cntld, cnten, maddw, mwidth, macc_first, macc_en, macc_last,
           busy, done, err
  );

  modport slave (
    input  go, mwidth_in, colmaj_in, mtxa_wr, mem_ready, abort,
    output cntld, cnten, maddw, mwidth, macc_first, macc_en, macc_last,
           busy, done, err
  );
endinterface

// File: rtl/mmult_seq.sv
// mmult_seq -- sequencer for one matrix-multiply dot product.
//
// On an accepted go it latches the element count and addressing stride,
// then issues one address-counter step per granted RAM read slot. The
// accumulator strobes trail the steps by one cycle to match the RAM read
// latency. After the last issue a single DRAIN cycle lets the final read
// land, then a DONE cycle; the done flag is registered from DONE.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mmult_seq_if.slave (go/width/colmaj/mtxa_wr/mem_ready/abort in;
//           cntld/cnten/maddw/mwidth/macc_*/busy/done/err out)
//
// Build option: define MMULT_SEQ_ABORT_EN to honour the abort input; when it
// is undefined the abort input is present but ignored.
module mmult_seq (
  input  logic       clk,
  input  logic       reset,
  mmult_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] remaining_reg, remaining_next;
  logic [3:0] mwidth_reg;
  logic       maddw_reg;
  logic       macc_en_reg, macc_first_reg, macc_last_reg;
  logic       done_reg, err_reg;

  logic       abort_eff;
  logic       accept_go;
  logic       issue;
  logic       busy;
  logic       err_next;

`ifdef MMULT_SEQ_ABORT_EN
  assign abort_eff = bus.abort;
`else
  assign abort_eff = 1'b0;
`endif

  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign accept_go = (state_reg == IDLE) && bus.go && (bus.mwidth_in != 4'd0);
  assign issue     = (state_reg == RUN) && bus.mem_ready && !abort_eff;

  // Zero-width go, or a matrix-address write while the counter is in use.
  assign err_next  = ((state_reg == IDLE) && bus.go && (bus.mwidth_in == 4'd0))
                   || (bus.mtxa_wr && busy);

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (accept_go) begin
          state_next     = RUN;
          remaining_next = bus.mwidth_in;
        end
      end
      RUN: begin
        if (abort_eff) begin
          state_next     = IDLE;
          remaining_next = 4'd0;
        end else if (issue) begin
          remaining_next = remaining_reg - 4'd1;
          if (remaining_reg == 4'd1) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_eff) state_next = IDLE;
        else           state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      remaining_reg  <= 4'd0;
      mwidth_reg     <= 4'd0;
      maddw_reg      <= 1'b0;
      macc_en_reg    <= 1'b0;
      macc_first_reg <= 1'b0;
      macc_last_reg  <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      if (accept_go) begin
        mwidth_reg <= bus.mwidth_in;
        maddw_reg  <= bus.colmaj_in;
      end
      // remaining starts at mwidth, so equality marks the first issue.
      macc_en_reg    <= issue;
      macc_first_reg <= issue && (remaining_reg == mwidth_reg);
      macc_last_reg  <= issue && (remaining_reg == 4'd1);
      done_reg       <= (state_reg == DONE);
      err_reg        <= err_next;
    end
  end

  // Accumulator strobes of an aborted cycle must not reach the MAC.
  logic macc_kill;
  assign macc_kill = busy && abort_eff;

  // cntld is gated by reset so every output is quiet while reset is held.
  assign bus.cntld      = bus.mtxa_wr && !reset
                        && ((state_reg == IDLE) || (state_reg == DONE));
  assign bus.cnten      = issue;
  assign bus.maddw      = maddw_reg;
  assign bus.mwidth     = mwidth_reg;
  assign bus.macc_en    = macc_en_reg    && !macc_kill;
  assign bus.macc_first = macc_first_reg && !macc_kill;
  assign bus.macc_last  = macc_last_reg  && !macc_kill;
  assign bus.busy       = busy;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;

endmodule
